// File: rtl/k423_hzd_pkg.sv
// Shared constants and types for the k423 hazard/control slice.
// Stage indices name the pipe register that feeds each stage (0 is the PC).
package k423_hzd_pkg;

   localparam int NSTAGE_DEF = 4;
   localparam int RIDX_W_DEF = 5;

   localparam int STG_PC    = 0;
   localparam int STG_IF_ID = 1;
   localparam int STG_ID_EX = 2;
   localparam int STG_EX_WB = 3;

   typedef logic [NSTAGE_DEF-1:0] stg_vec_t;

endpackage

// File: rtl/k423_scoreboard.sv
// Per-register pending scoreboard for long-latency results, with outstanding
// op limit, writeback bypass and a sticky error for unmatched completions.
module k423_scoreboard #(
   parameter int RIDX_W   = 5,
   parameter int MAX_PEND = 2
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              rs1_vld_i,
   input  logic [RIDX_W-1:0] rs1_idx_i,
   input  logic              rs2_vld_i,
   input  logic [RIDX_W-1:0] rs2_idx_i,
   input  logic              issue_i,
   input  logic              rd_vld_i,
   input  logic [RIDX_W-1:0] rd_idx_i,
   input  logic              rd_long_i,
   input  logic              done_i,
   input  logic [RIDX_W-1:0] done_idx_i,
   output logic              hazard_o,
   output logic              sb_err_o
);

   localparam int NREG = 1 << RIDX_W;
   localparam int PCW  = $clog2(MAX_PEND + 1);
   localparam logic [PCW-1:0] MAX_CNT = PCW'(MAX_PEND);
   localparam logic [NREG-1:0] X0_MASK = NREG'(1);

   logic [NREG-1:0] pend_reg, pend_next, pend_eff, done_mask, set_mask;
   logic [PCW-1:0]  cnt_reg, cnt_next;
   logic            err_reg, err_next;
   logic            long_iss, issue_ok, raw_hz, waw_hz, struct_hz;

   always_comb begin
      done_mask = '0;
      if (done_i)
         done_mask[done_idx_i] = 1'b1;
      // A result written back this cycle is already visible through the regfile.
      pend_eff  = pend_reg & ~done_mask;

      long_iss  = issue_i & rd_vld_i & rd_long_i;
      raw_hz    = (rs1_vld_i & pend_eff[rs1_idx_i]) | (rs2_vld_i & pend_eff[rs2_idx_i]);
      waw_hz    = long_iss & pend_eff[rd_idx_i];
      struct_hz = long_iss & (cnt_reg == MAX_CNT) & ~done_i;
      hazard_o  = raw_hz | waw_hz | struct_hz;
      issue_ok  = long_iss & ~hazard_o;

      set_mask = '0;
      if (issue_ok)
         set_mask[rd_idx_i] = 1'b1;
      // Set wins over a same-cycle clear of the same index; x0 is never pending.
      pend_next = (set_mask | (pend_reg & ~done_mask)) & ~X0_MASK;

      cnt_next = cnt_reg;
      err_next = err_reg;
      if (done_i && cnt_reg == '0)
         err_next = 1'b1;
      if (issue_ok && !done_i)
         cnt_next = cnt_reg + 1'b1;
      else if (!issue_ok && done_i && cnt_reg != '0)
         cnt_next = cnt_reg - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_reg <= '0;
         cnt_reg  <= '0;
         err_reg  <= 1'b0;
      end else begin
         pend_reg <= pend_next;
         cnt_reg  <= cnt_next;
         err_reg  <= err_next;
      end
   end

   assign sb_err_o = err_reg;

endmodule

// File: rtl/k423_hzd_ctrl.sv
// Pipeline hazard/control unit: per-register stall/clear vectors from decode
// hazards, memory wait and redirects, plus saturating performance counters.
module k423_hzd_ctrl
   import k423_hzd_pkg::*;
#(
   parameter int NSTAGE   = NSTAGE_DEF,
   parameter int ID_STAGE = STG_IF_ID,
   parameter int BR_STAGE = STG_EX_WB,
   parameter int RIDX_W   = RIDX_W_DEF,
   parameter int MAX_PEND = 2,
   parameter int CNT_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              id_rs1_vld_i,
   input  logic [RIDX_W-1:0] id_rs1_idx_i,
   input  logic              id_rs2_vld_i,
   input  logic [RIDX_W-1:0] id_rs2_idx_i,
   input  logic              id_issue_i,
   input  logic              id_rd_vld_i,
   input  logic [RIDX_W-1:0] id_rd_idx_i,
   input  logic              id_rd_long_i,
   input  logic              wb_long_done_i,
   input  logic [RIDX_W-1:0] wb_long_idx_i,
   input  logic              ex_mem_busy_i,
   input  logic              wb_bju_br_tkn_i,
   input  logic              wb_excp_br_tkn_i,
   output logic [NSTAGE-1:0] pcu_stall_o,
   output logic [NSTAGE-1:0] pcu_clear_o,
   output logic              sb_err_o,
   output logic [CNT_W-1:0]  perf_stall_cyc_o,
   output logic [CNT_W-1:0]  perf_flush_cnt_o
);

   logic             hazard, flush;
   logic [CNT_W-1:0] stall_cyc_reg, flush_cnt_reg;

   k423_scoreboard #(
      .RIDX_W   (RIDX_W),
      .MAX_PEND (MAX_PEND)
   ) u_sb (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .rs1_vld_i  (id_rs1_vld_i),
      .rs1_idx_i  (id_rs1_idx_i),
      .rs2_vld_i  (id_rs2_vld_i),
      .rs2_idx_i  (id_rs2_idx_i),
      .issue_i    (id_issue_i),
      .rd_vld_i   (id_rd_vld_i),
      .rd_idx_i   (id_rd_idx_i),
      .rd_long_i  (id_rd_long_i),
      .done_i     (wb_long_done_i),
      .done_idx_i (wb_long_idx_i),
      .hazard_o   (hazard),
      .sb_err_o   (sb_err_o)
   );

   assign flush = wb_bju_br_tkn_i | wb_excp_br_tkn_i;

   // Priority per index: redirect (up to BR_STAGE) > memory wait > decode hazard.
   for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stg
      localparam bit IN_BR  = (gi <= BR_STAGE);
      localparam bit FL_CLR = (gi >= 1) && (gi <= BR_STAGE);
      localparam bit IN_ID  = (gi <= ID_STAGE);
      localparam bit BUBBLE = (gi == ID_STAGE + 1);

      assign pcu_stall_o[gi] = (flush && IN_BR) ? 1'b0 :
                               ex_mem_busy_i    ? 1'b1 : (hazard && IN_ID);
      assign pcu_clear_o[gi] = (flush && IN_BR) ? FL_CLR :
                               ex_mem_busy_i    ? 1'b0 : (hazard && BUBBLE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cyc_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if ((|pcu_stall_o) && stall_cyc_reg != '1)
            stall_cyc_reg <= stall_cyc_reg + 1'b1;
         if (flush && flush_cnt_reg != '1)
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
   end

   assign perf_stall_cyc_o = stall_cyc_reg;
   assign perf_flush_cnt_o = flush_cnt_reg;

endmodule
